riscv_div_unit: RTL and testbench

- Iterative RV32M divide unit and its sequencer for the Execute stage. It handles DIV, DIVU, REM and REMU.
- It accepts an M-extension divide sitting in E and stalls the pipeline while it runs.
- It runs one restoring-division step per cycle, then presents the sign-corrected result for the EX/MEM register to capture.
- The stall output feeds the hazard unit, which holds E stable and deasserts EX_MEM_en.

---
 rtl/riscv_div_unit_pkg.sv | 24 ++
 rtl/riscv_div_unit_div_restore_step.sv | 26 ++
 rtl/riscv_div_unit.sv | 152 +++++++++++++++
 tb/tb_riscv_div_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_div_unit_pkg.sv
// Shared types and opcode constants for the RV32M iterative divide unit.
package riscv_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    function automatic logic is_signed_op(input logic [2:0] funct3);
        return ~funct3[0];
    endfunction

    function automatic logic is_rem_op(input logic [2:0] funct3);
        return funct3[1];
    endfunction

endpackage

// File: rtl/riscv_div_unit_div_restore_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor when it fits.
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // Shifted remainder needs one extra bit: divisors above 2^(WIDTH-1) can overflow it.
    logic [WIDTH:0] rem_sh;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        if (rem_sh >= {1'b0, divisor_i}) begin
            rem_o = WIDTH'(rem_sh - {1'b0, divisor_i});
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/riscv_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU sequencer for the E stage; stalls the pipe while dividing.
// Optional macro RISCV_DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module riscv_div_unit
    import riscv_div_unit_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             start_E,
    input  logic [2:0]       funct3_E,
    input  logic [WIDTH-1:0] rs1_data_E,
    input  logic [WIDTH-1:0] rs2_data_E,
    input  logic             flush_E,
    output logic             stall_E,
    output logic             busy_E,
    output logic             done_E,
    output logic [WIDTH-1:0] result_E
);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             op_rem_q, op_rem_d;
    logic             quot_neg_q, quot_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             rs1_neg, rs2_neg, div_zero, overflow, early_out;
    logic [WIDTH-1:0] rs1_mag, rs2_mag, step_rem, step_quo, quo_fix, rem_fix, final_res;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        rs1_neg  = is_signed_op(funct3_E) & rs1_data_E[WIDTH-1];
        rs2_neg  = is_signed_op(funct3_E) & rs2_data_E[WIDTH-1];
        rs1_mag  = rs1_neg ? -rs1_data_E : rs1_data_E;
        rs2_mag  = rs2_neg ? -rs2_data_E : rs2_data_E;
        div_zero = (rs2_data_E == '0);
        overflow = is_signed_op(funct3_E)
                   && (rs1_data_E == {1'b1, {(WIDTH-1){1'b0}}})
                   && (rs2_data_E == '1);
`ifdef RISCV_DIV_EARLY_OUT_EN
        early_out = !div_zero && (rs1_mag < rs2_mag);
`else
        early_out = 1'b0;
`endif
        quo_fix   = quot_neg_q ? -quo_q : quo_q;
        rem_fix   = rem_neg_q ? -rem_q : rem_q;
        final_res = op_rem_q ? rem_fix : quo_fix;
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        op_rem_d   = op_rem_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        stall_E    = 1'b0;
        done_E     = 1'b0;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_E && funct3_E[2] && !flush_E) begin
                    stall_E    = 1'b1;
                    count_d    = '0;
                    op_rem_d   = is_rem_op(funct3_E);
                    divisor_d  = rs2_mag;
                    quot_neg_d = rs1_neg ^ rs2_neg;
                    rem_neg_d  = rs1_neg;
                    state_d    = DIV_DONE;
                    // Architectural special cases bypass the sign fix entirely.
                    if (div_zero) begin
                        quo_d      = '1;
                        rem_d      = rs1_data_E;
                        quot_neg_d = 1'b0;
                        rem_neg_d  = 1'b0;
                    end else if (overflow) begin
                        quo_d      = {1'b1, {(WIDTH-1){1'b0}}};
                        rem_d      = '0;
                        quot_neg_d = 1'b0;
                        rem_neg_d  = 1'b0;
                    end else if (early_out) begin
                        quo_d = '0;
                        rem_d = rs1_mag;
                    end else begin
                        quo_d   = rs1_mag;
                        rem_d   = '0;
                        state_d = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                stall_E = 1'b1;
                if (flush_E) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (count_q == CNT_W'(WIDTH-1)) state_d = DIV_DONE;
                    else                            count_d = count_q + CNT_W'(1);
                end
            end
            DIV_DONE: begin
                done_E   = !flush_E;
                result_d = final_res;
                state_d  = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= DIV_IDLE;
            count_q    <= '0;
            op_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            op_rem_q   <= op_rem_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
        end
    end

    assign busy_E   = (state_q != DIV_IDLE);
    assign result_E = (state_q == DIV_DONE) ? final_res : result_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed-vector bench for riscv_div_unit: results, stall latency, flush and reset behaviour.
module tb_riscv_div_unit;
    import riscv_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_l = 1'b1;
    logic        start_E = 1'b0;
    logic        flush_E = 1'b0;
    logic [2:0]  funct3_E = 3'b000;
    logic [31:0] rs1_data_E = '0;
    logic [31:0] rs2_data_E = '0;
    logic        stall_E, busy_E, done_E;
    logic [31:0] result_E;

    int vectors = 0;
    int errors  = 0;

`ifdef RISCV_DIV_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 33;
`endif

    riscv_div_unit dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .start_E    (start_E),
        .funct3_E   (funct3_E),
        .rs1_data_E (rs1_data_E),
        .rs2_data_E (rs2_data_E),
        .flush_E    (flush_E),
        .stall_E    (stall_E),
        .busy_E     (busy_E),
        .done_E     (done_E),
        .result_E   (result_E)
    );

    always #5 clk = ~clk;

    // Called just after a negedge; holds start until done, returns just after a negedge.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls, output logic [31:0] res);
        lat = -1; stalls = 0; res = 'x;
        funct3_E = f3; rs1_data_E = a; rs2_data_E = b; start_E = 1'b1;
        for (int c = 0; c < 80 && lat < 0; c++) begin
            #2;
            if (stall_E) stalls++;
            if (done_E) begin lat = c; res = result_E; end
            @(negedge clk);
        end
        start_E = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_l = 1'b0;
        #2;
        vectors++;
        if ({stall_E, busy_E, done_E} !== 3'b000 || result_E !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%b busy=%b done=%b result=%h, required 0 0 0 00000000",
                     stall_E, busy_E, done_E, result_E);
        end
        @(negedge clk); rst_l = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        int lat, st; logic [31:0] r;
        do_op(FUNCT3_DIVU, 32'd100, 32'd7, lat, st, r);
        vectors++;
        if (r !== 32'd14 || lat !== 33 || st !== 33) begin
            errors++;
            $display("FAIL divu_100_7: result=%h lat=%0d stalls=%0d, required 0000000e 33 33", r, lat, st);
        end
        #2;
        vectors++;
        if (done_E !== 1'b0 || stall_E !== 1'b0 || result_E !== 32'd14) begin
            errors++;
            $display("FAIL done_one_cycle: done=%b stall=%b result=%h, required 0 0 0000000e",
                     done_E, stall_E, result_E);
        end
        @(negedge clk);
        do_op(FUNCT3_REMU, 32'd100, 32'd7, lat, st, r);
        vectors++;
        if (r !== 32'd2 || lat !== 33) begin
            errors++;
            $display("FAIL remu_100_7: result=%h lat=%0d, required 00000002 33", r, lat);
        end
        do_op(FUNCT3_REMU, 32'hFFFFFFFF, 32'h80000001, lat, st, r);
        vectors++;
        if (r !== 32'h7FFFFFFE) begin
            errors++;
            $display("FAIL remu_big_divisor: result=%h, required 7ffffffe", r);
        end
        do_op(FUNCT3_DIVU, 32'hFFFFFFFF, 32'h80000001, lat, st, r);
        vectors++;
        if (r !== 32'h1) begin
            errors++;
            $display("FAIL divu_big_divisor: result=%h, required 00000001", r);
        end
    endtask

    task automatic test_signed;
        int lat, st; logic [31:0] r;
        do_op(FUNCT3_DIV, 32'd20, 32'hFFFFFFFD, lat, st, r);
        vectors++;
        if (r !== 32'hFFFFFFFA || lat !== 33) begin
            errors++;
            $display("FAIL div_20_m3: result=%h lat=%0d, required fffffffa 33", r, lat);
        end
        do_op(FUNCT3_REM, 32'd20, 32'hFFFFFFFD, lat, st, r);
        vectors++;
        if (r !== 32'd2) begin
            errors++;
            $display("FAIL rem_20_m3: result=%h, required 00000002", r);
        end
        do_op(FUNCT3_REM, 32'hFFFFFFF9, 32'd2, lat, st, r);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL rem_m7_2: result=%h, required ffffffff", r);
        end
        do_op(FUNCT3_DIV, 32'hFFFFFFEC, 32'hFFFFFFFD, lat, st, r);
        vectors++;
        if (r !== 32'd6) begin
            errors++;
            $display("FAIL div_m20_m3: result=%h, required 00000006", r);
        end
    endtask

    task automatic test_div_zero;
        int lat, st; logic [31:0] r;
        do_op(FUNCT3_DIVU, 32'd5, 32'd0, lat, st, r);
        vectors++;
        if (r !== 32'hFFFFFFFF || lat !== 1 || st !== 1) begin
            errors++;
            $display("FAIL divu_5_0: result=%h lat=%0d stalls=%0d, required ffffffff 1 1", r, lat, st);
        end
        do_op(FUNCT3_REM, 32'hFFFFFFF7, 32'd0, lat, st, r);
        vectors++;
        if (r !== 32'hFFFFFFF7 || lat !== 1 || st !== 1) begin
            errors++;
            $display("FAIL rem_m9_0: result=%h lat=%0d stalls=%0d, required fffffff7 1 1", r, lat, st);
        end
        do_op(FUNCT3_DIV, 32'hFFFFFFF7, 32'd0, lat, st, r);
        vectors++;
        if (r !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_m9_0: result=%h, required ffffffff", r);
        end
    endtask

    task automatic test_overflow;
        int lat, st; logic [31:0] r;
        do_op(FUNCT3_DIV, 32'h80000000, 32'hFFFFFFFF, lat, st, r);
        vectors++;
        if (r !== 32'h80000000 || lat !== 1 || st !== 1) begin
            errors++;
            $display("FAIL div_overflow: result=%h lat=%0d stalls=%0d, required 80000000 1 1", r, lat, st);
        end
        do_op(FUNCT3_REM, 32'h80000000, 32'hFFFFFFFF, lat, st, r);
        vectors++;
        if (r !== 32'h0 || lat !== 1) begin
            errors++;
            $display("FAIL rem_overflow: result=%h lat=%0d, required 00000000 1", r, lat);
        end
        do_op(FUNCT3_DIVU, 32'h80000000, 32'hFFFFFFFF, lat, st, r);
        vectors++;
        if (r !== 32'h0 || lat !== 33) begin
            errors++;
            $display("FAIL divu_no_overflow: result=%h lat=%0d, required 00000000 33", r, lat);
        end
    endtask

    task automatic test_flush;
        int lat, st, bad; logic [31:0] r, prev;
        prev = result_E;
        bad = 0;
        funct3_E = FUNCT3_DIVU; rs1_data_E = 32'd1000; rs2_data_E = 32'd7; start_E = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #2;
            if (!stall_E || done_E) bad++;
            @(negedge clk);
        end
        flush_E = 1'b1; start_E = 1'b0;
        #2;
        vectors++;
        if (stall_E !== 1'b1 || busy_E !== 1'b1 || bad != 0) begin
            errors++;
            $display("FAIL flush_calc_cycle: stall=%b busy=%b early_errs=%0d, required 1 1 0",
                     stall_E, busy_E, bad);
        end
        @(negedge clk); flush_E = 1'b0;
        #2;
        vectors++;
        if ({stall_E, busy_E, done_E} !== 3'b000 || result_E !== prev) begin
            errors++;
            $display("FAIL flush_to_idle: stall=%b busy=%b done=%b result=%h, required 0 0 0 %h",
                     stall_E, busy_E, done_E, result_E, prev);
        end
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #2;
            if (done_E || busy_E) bad++;
        end
        vectors++;
        if (bad != 0) begin
            errors++;
            $display("FAIL flush_no_done: bad_cycles=%0d, required 0", bad);
        end
        @(negedge clk);
        do_op(FUNCT3_DIVU, 32'd9, 32'd3, lat, st, r);
        vectors++;
        if (r !== 32'd3 || lat !== 33) begin
            errors++;
            $display("FAIL divu_9_3_after_flush: result=%h lat=%0d, required 00000003 33", r, lat);
        end
    endtask

    task automatic test_back_to_back;
        int lat, st; logic [31:0] r;
        do_op(FUNCT3_DIV, 32'd50, 32'd5, lat, st, r);
        do_op(FUNCT3_REM, 32'd53, 32'd5, lat, st, r);
        vectors++;
        if (r !== 32'd3 || lat !== 33) begin
            errors++;
            $display("FAIL back_to_back_second: result=%h lat=%0d, required 00000003 33", r, lat);
        end
        funct3_E = FUNCT3_DIV; rs1_data_E = 32'd100; rs2_data_E = 32'd9; start_E = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        rst_l = 1'b0; start_E = 1'b0;
        #1;
        vectors++;
        if ({stall_E, busy_E, done_E} !== 3'b000 || result_E !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_calc: stall=%b busy=%b done=%b result=%h, required 0 0 0 00000000",
                     stall_E, busy_E, done_E, result_E);
        end
        @(negedge clk); rst_l = 1'b1;
        @(negedge clk);
        do_op(FUNCT3_DIV, 32'd7, 32'd2, lat, st, r);
        vectors++;
        if (r !== 32'd3 || lat !== 33) begin
            errors++;
            $display("FAIL div_7_2_after_reset: result=%h lat=%0d, required 00000003 33", r, lat);
        end
    endtask

    task automatic test_early_out;
        int lat, st; logic [31:0] r;
        do_op(FUNCT3_DIVU, 32'd3, 32'd10, lat, st, r);
        vectors++;
        if (r !== 32'd0 || lat !== EO_LAT || st !== EO_LAT) begin
            errors++;
            $display("FAIL divu_3_10: result=%h lat=%0d stalls=%0d, required 00000000 %0d %0d",
                     r, lat, st, EO_LAT, EO_LAT);
        end
        do_op(FUNCT3_REM, 32'hFFFFFFFD, 32'd10, lat, st, r);
        vectors++;
        if (r !== 32'hFFFFFFFD || lat !== EO_LAT) begin
            errors++;
            $display("FAIL rem_m3_10: result=%h lat=%0d, required fffffffd %0d", r, lat, EO_LAT);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_early_out();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
